// File: rtl/id_pkg.sv
// Shared decode definitions for the ID stage of the pipelined MIPS datapath.
//   - opcode / funct encodings of the supported instruction subset
//   - ALU operation encodings (aluc_e)
//   - decoded control bundle (ctrl_t) and the decode() helper
package id_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0100,
    ALU_AND = 4'b0001,
    ALU_OR  = 4'b0101,
    ALU_XOR = 4'b0010,
    ALU_SLL = 4'b0011,
    ALU_SRL = 4'b0111,
    ALU_SRA = 4'b1111
  } aluc_e;

  typedef struct packed {
    logic  wreg;
    logic  m2reg;
    logic  wmem;
    logic  aluimm;
    aluc_e aluc;
    logic  illegal;
  } ctrl_t;

  // Unknown encodings come back as illegal with every side-effect bit clear,
  // so they travel down the pipe harmlessly.
  function automatic ctrl_t decode(input logic [5:0] op, input logic [5:0] funct);
    ctrl_t c;
    c = '0;
    case (op)
      OP_RTYPE: begin
        c.wreg = 1'b1;
        case (funct)
          FN_ADD:  c.aluc = ALU_ADD;
          FN_SUB:  c.aluc = ALU_SUB;
          FN_AND:  c.aluc = ALU_AND;
          FN_OR:   c.aluc = ALU_OR;
          FN_XOR:  c.aluc = ALU_XOR;
          FN_SLL:  c.aluc = ALU_SLL;
          FN_SRL:  c.aluc = ALU_SRL;
          FN_SRA:  c.aluc = ALU_SRA;
          default: begin
            c.wreg    = 1'b0;
            c.illegal = 1'b1;
          end
        endcase
      end
      OP_ADDI: begin c.wreg = 1'b1; c.aluimm = 1'b1; c.aluc = ALU_ADD; end
      OP_ANDI: begin c.wreg = 1'b1; c.aluimm = 1'b1; c.aluc = ALU_AND; end
      OP_ORI:  begin c.wreg = 1'b1; c.aluimm = 1'b1; c.aluc = ALU_OR;  end
      OP_LW:   begin c.wreg = 1'b1; c.m2reg = 1'b1; c.aluimm = 1'b1; c.aluc = ALU_ADD; end
      OP_SW:   begin c.wmem = 1'b1; c.aluimm = 1'b1; c.aluc = ALU_ADD; end
      default: c.illegal = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/id_regfile.sv
// Register file for the ID stage: NREGS x XLEN, two combinational read
// ports with write-before-read bypass from the write-back port.
// Ports:
//   clk, rst                   clock, synchronous active-high reset (clears all)
//   we, waddr, wdata           write-back port
//   raddr_a/b -> rdata_a/b     read ports (bypassed)
// ZERO_REG=1 makes register 0 a constant zero.
module id_regfile #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr_a,
  input  logic [AW-1:0]   raddr_b,
  output logic [XLEN-1:0] rdata_a,
  output logic [XLEN-1:0] rdata_b
);

  logic [XLEN-1:0] regs [NREGS];
  logic            wr_ok;

  assign wr_ok = we && ((waddr != '0) || (ZERO_REG == 0));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  // NOTE: clearing every entry on reset forces the array into flops (no RAM
  // inference); the pipeline relies on a known all-zero register state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[waddr] <= wdata;
    end
  end

  // NOTE: each output is assigned a default first so no path can infer a latch.
  always_comb begin
    rdata_a = regs[raddr_a];
    if (wr_ok && (waddr == raddr_a)) rdata_a = wdata;
    if ((ZERO_REG != 0) && (raddr_a == '0)) rdata_a = '0;
  end

  always_comb begin
    rdata_b = regs[raddr_b];
    if (wr_ok && (waddr == raddr_b)) rdata_b = wdata;
    if ((ZERO_REG != 0) && (raddr_b == '0)) rdata_b = '0;
  end

endmodule

// File: rtl/id_stage_pipe.sv
// Instruction-decode stage with its own ID/EX pipeline register.
// Decodes the IF/ID instruction, reads the register file, sign-extends the
// immediate, selects Rd/Rt, detects RAW hazards against ID/EX and EX/MEM, and
// registers the result towards EX.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   in_valid, instruction, in_ready IF/ID handshake (in_ready=0 holds IF/ID)
//   flush                           kill the slot loaded this cycle
//   wb_we, wb_addr, wb_data         write-back port into the register file
//   ex_result                       ALU result of the instruction in ID/EX
//   mem_valid/wreg/m2reg/rd/data    EX/MEM register contents
//   ex_*                            registered ID/EX outputs to EX
// Build option: define ID_FWD_EN to forward from ID/EX and EX/MEM instead of
// stalling on every RAW hazard (only load results then stall).
module id_stage_pipe
  import id_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [31:0]     instruction,
  output logic            in_ready,
  input  logic            flush,
  input  logic            wb_we,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic [XLEN-1:0] ex_result,
  input  logic            mem_valid,
  input  logic            mem_wreg,
  input  logic            mem_m2reg,
  input  logic [AW-1:0]   mem_rd,
  input  logic [XLEN-1:0] mem_data,
  output logic            ex_valid,
  output logic            ex_wreg,
  output logic            ex_m2reg,
  output logic            ex_wmem,
  output logic            ex_aluimm,
  output logic            ex_illegal,
  output logic [3:0]      ex_aluc,
  output logic [AW-1:0]   ex_rd,
  output logic [XLEN-1:0] ex_a,
  output logic [XLEN-1:0] ex_b,
  output logic [XLEN-1:0] ex_imm
);

  logic [5:0]      op, funct;
  logic [AW-1:0]   rs, rt, rd_f, dest;
  logic [15:0]     imm16;
  logic [XLEN-1:0] imm_ext, rf_a, rf_b, op_a, op_b;
  ctrl_t           ctrl;
  logic            uses_rt;
  logic            ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
  logic            hazard, issue;

  assign op      = instruction[31:26];
  assign rs      = instruction[21 +: AW];
  assign rt      = instruction[16 +: AW];
  assign rd_f    = instruction[11 +: AW];
  assign funct   = instruction[5:0];
  assign imm16   = instruction[15:0];
  assign imm_ext = XLEN'($signed(imm16));

  assign ctrl    = decode(op, funct);
  assign uses_rt = (op == OP_RTYPE) || (op == OP_SW);
  assign dest    = ctrl.aluimm ? rt : rd_f;

  id_regfile #(
    .XLEN     (XLEN),
    .NREGS    (NREGS),
    .ZERO_REG (ZERO_REG)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (wb_we),
    .waddr   (wb_addr),
    .wdata   (wb_data),
    .raddr_a (rs),
    .raddr_b (rt),
    .rdata_a (rf_a),
    .rdata_b (rf_b)
  );

  // A producer targeting the hardwired zero register never creates a dependency.
  function automatic logic dest_ok(input logic [AW-1:0] d);
    return (d != '0) || (ZERO_REG == 0);
  endfunction

  assign ex_hit_a  = ex_valid && ex_wreg && dest_ok(ex_rd) && (ex_rd == rs);
  assign ex_hit_b  = ex_valid && ex_wreg && dest_ok(ex_rd) && uses_rt && (ex_rd == rt);
  assign mem_hit_a = mem_valid && mem_wreg && dest_ok(mem_rd) && (mem_rd == rs);
  assign mem_hit_b = mem_valid && mem_wreg && dest_ok(mem_rd) && uses_rt && (mem_rd == rt);

`ifdef ID_FWD_EN
  // Youngest producer wins. A load result is not yet available in either
  // stage, so a match against a load stalls instead of forwarding.
  logic stall_a, stall_b;
  assign stall_a = ex_hit_a ? ex_m2reg : (mem_hit_a && mem_m2reg);
  assign stall_b = ex_hit_b ? ex_m2reg : (mem_hit_b && mem_m2reg);
  assign hazard  = stall_a || stall_b;
  assign op_a    = ex_hit_a ? ex_result : (mem_hit_a ? mem_data : rf_a);
  assign op_b    = ex_hit_b ? ex_result : (mem_hit_b ? mem_data : rf_b);
`else
  // Without forwarding, wait until the producer reaches write-back, where the
  // register-file bypass supplies the value.
  logic unused_fwd;
  assign unused_fwd = ^{ex_result, mem_data, mem_m2reg};
  assign hazard     = ex_hit_a || ex_hit_b || mem_hit_a || mem_hit_b;
  assign op_a       = rf_a;
  assign op_b       = rf_b;
`endif

  assign in_ready = !(in_valid && hazard);
  assign issue    = in_valid && in_ready && !flush;

  // Operands are loaded every cycle; in a bubble they are don't-care because
  // all control bits (and ex_valid) are cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid   <= 1'b0;
      ex_wreg    <= 1'b0;
      ex_m2reg   <= 1'b0;
      ex_wmem    <= 1'b0;
      ex_aluimm  <= 1'b0;
      ex_illegal <= 1'b0;
      ex_aluc    <= '0;
      ex_rd      <= '0;
      ex_a       <= '0;
      ex_b       <= '0;
      ex_imm     <= '0;
    end else begin
      ex_a   <= op_a;
      ex_b   <= op_b;
      ex_imm <= imm_ext;
      if (issue) begin
        ex_valid   <= 1'b1;
        ex_wreg    <= ctrl.wreg;
        ex_m2reg   <= ctrl.m2reg;
        ex_wmem    <= ctrl.wmem;
        ex_aluimm  <= ctrl.aluimm;
        ex_illegal <= ctrl.illegal;
        ex_aluc    <= ctrl.aluc;
        ex_rd      <= dest;
      end else begin
        ex_valid   <= 1'b0;
        ex_wreg    <= 1'b0;
        ex_m2reg   <= 1'b0;
        ex_wmem    <= 1'b0;
        ex_aluimm  <= 1'b0;
        ex_illegal <= 1'b0;
        ex_aluc    <= '0;
        ex_rd      <= '0;
      end
    end
  end

endmodule
